// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing / pattern blocks.
// Holds the pattern encodings, the 640x480@60 default timing and the counter width.
// No logic; imported by vga_timing and vga_pattern_gen.
package vga_pkg;

    // Column/row counters are this wide; the total raster must fit in it.
    localparam int CNT_W     = 10;
    localparam int MAX_COUNT = 1 << CNT_W;

    // 640x480 @ 60 Hz default timing (25 MHz pixel clock).
    localparam int DEF_ACTIVE_COLS = 640;
    localparam int DEF_ACTIVE_ROWS = 480;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;

    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_WHITE   = 3'd1,
        PAT_HALF    = 3'd2,
        PAT_BARS    = 3'd3,
        PAT_CHECKER = 3'd4,
        PAT_BORDER  = 3'd5,
        PAT_MOVING  = 3'd6,
        PAT_RSVD    = 3'd7
    } pattern_e;

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus combinational sync / active / frame-marker decode.
// Latency: decode is combinational from the counter flops (registered by the parent).
// Backpressure: none, free-running at one pixel per clock.
// Ports: i_Clk, i_Rst (async, active high); o_Col/o_Row current counters;
//        o_HSync/o_VSync active-low syncs; o_Active visible area;
//        o_Frame_Start at (0,0); o_Frame_End at the last pixel of the frame.
module vga_timing
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    output logic [CNT_W-1:0] o_Col,
    output logic [CNT_W-1:0] o_Row,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic             o_Active,
    output logic             o_Frame_Start,
    output logic             o_Frame_End
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;
    localparam int HS_START   = ACTIVE_COLS + H_FP;
    localparam int HS_END     = HS_START + H_SYNC;
    localparam int VS_START   = ACTIVE_ROWS + V_FP;
    localparam int VS_END     = VS_START + V_SYNC;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             last_col;
    logic             last_row;

    always_comb begin
        last_col = (int'(col_q) == TOTAL_COLS - 1);
        last_row = (int'(row_q) == TOTAL_ROWS - 1);
        col_d    = col_q + ONE;
        row_d    = row_q;
        if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ONE;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Comparisons are done in int so ranges touching the counter limit cannot wrap.
    assign o_Col         = col_q;
    assign o_Row         = row_q;
    assign o_HSync       = !(int'(col_q) >= HS_START && int'(col_q) < HS_END);
    assign o_VSync       = !(int'(row_q) >= VS_START && int'(row_q) < VS_END);
    assign o_Active      = (int'(col_q) < ACTIVE_COLS) && (int'(row_q) < ACTIVE_ROWS);
    assign o_Frame_Start = (col_q == '0) && (row_q == '0);
    assign o_Frame_End   = last_col && last_row;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus runtime-selectable test-pattern engine, pin-ready outputs.
// Latency: one clock from counter value to every output (all in one register stage).
// Backpressure: none; the raster free-runs, i_Pattern is only sampled at pixel (0,0).
// Ports: i_Clk, i_Rst (async, active high), i_Pattern (3b select);
//        o_HSync/o_VSync active low, o_Red/o_Grn/o_Blu colour, o_Active,
//        o_Frame_Start pulse with pixel (0,0), o_Col/o_Row output pixel coordinates.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter int CHK_LOG2    = 5,
    parameter int BAR_W       = 32,
    parameter int BAR_STEP    = 4
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic [2:0]             i_Pattern,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red,
    output logic [VIDEO_WIDTH-1:0] o_Grn,
    output logic [VIDEO_WIDTH-1:0] o_Blu,
    output logic                   o_Active,
    output logic                   o_Frame_Start,
    output logic [CNT_W-1:0]       o_Col,
    output logic [CNT_W-1:0]       o_Row
);

    localparam int TOTAL_COLS = ACTIVE_COLS + H_FP + H_SYNC + H_BP;
    localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FP + V_SYNC + V_BP;
    localparam int BAR_COLS   = ACTIVE_COLS / 8;
    localparam logic [VIDEO_WIDTH-1:0] FULL = '1;
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(BAR_STEP);

    if (TOTAL_COLS > MAX_COUNT || TOTAL_ROWS > MAX_COUNT) begin : g_chk_total
        $error("vga_pattern_gen: total raster exceeds the counter range");
    end
    if (ACTIVE_COLS % 8 != 0) begin : g_chk_cols
        $error("vga_pattern_gen: ACTIVE_COLS must be a multiple of 8");
    end
    if (BAR_W > ACTIVE_COLS) begin : g_chk_bar
        $error("vga_pattern_gen: BAR_W wider than the active area");
    end

    logic [CNT_W-1:0] t_col, t_row;
    logic             t_hsync, t_vsync, t_active, t_frame_start, t_frame_end;

    vga_timing #(
        .ACTIVE_COLS(ACTIVE_COLS), .ACTIVE_ROWS(ACTIVE_ROWS),
        .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .o_Col         (t_col),
        .o_Row         (t_row),
        .o_HSync       (t_hsync),
        .o_VSync       (t_vsync),
        .o_Active      (t_active),
        .o_Frame_Start (t_frame_start),
        .o_Frame_End   (t_frame_end)
    );

    pattern_e         pattern_q, pattern_d;
    logic [CNT_W-1:0] bar_pos_q, bar_pos_d;
    logic [2:0]       bar_idx;
    logic             in_bar;

    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic [VIDEO_WIDTH-1:0] red_q, red_d;
    logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
    logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
    logic                   active_q, active_d;
    logic                   frame_start_q, frame_start_d;
    logic [CNT_W-1:0]       col_q, col_d;
    logic [CNT_W-1:0]       row_q, row_d;

    // pattern_d feeds the colour decode directly, so a select sampled at (0,0)
    // already governs that pixel and stays frozen for the rest of the frame.
    // bar_pos steps on the last pixel of a frame, so the new position is in the
    // flop when (0,0) is coloured; the first frame after reset draws at 0.
    always_comb begin
        pattern_d = pattern_q;
        if (t_frame_start) begin
            pattern_d = pattern_e'(i_Pattern);
        end
        bar_pos_d = bar_pos_q;
        if (t_frame_end) begin
            if (int'(bar_pos_q) + BAR_STEP > ACTIVE_COLS - BAR_W) begin
                bar_pos_d = '0;
            end else begin
                bar_pos_d = bar_pos_q + STEP_C;
            end
        end
    end

    // Vertical-bar index from seven constant edge comparators; the lowest
    // edge the column is below wins.
    always_comb begin
        bar_idx = 3'd7;
        for (int k = 6; k >= 0; k--) begin
            if (int'(t_col) < (k + 1) * BAR_COLS) begin
                bar_idx = 3'(k);
            end
        end
        in_bar = (int'(t_col) >= int'(bar_pos_q)) &&
                 (int'(t_col) < int'(bar_pos_q) + BAR_W);
    end

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (t_active) begin
            case (pattern_d)
                PAT_WHITE: begin
                    red_d = FULL; grn_d = FULL; blu_d = FULL;
                end
                PAT_HALF: begin
                    red_d = FULL;
                    if (int'(t_col) < ACTIVE_COLS / 2) grn_d = FULL;
                end
                PAT_BARS: begin
                    red_d = {VIDEO_WIDTH{bar_idx[2]}};
                    grn_d = {VIDEO_WIDTH{bar_idx[1]}};
                    blu_d = {VIDEO_WIDTH{bar_idx[0]}};
                end
                PAT_CHECKER: begin
                    if (t_col[CHK_LOG2] ^ t_row[CHK_LOG2]) begin
                        red_d = FULL; grn_d = FULL; blu_d = FULL;
                    end
                end
                PAT_BORDER: begin
                    if (t_col == '0 || int'(t_col) == ACTIVE_COLS - 1 ||
                        t_row == '0 || int'(t_row) == ACTIVE_ROWS - 1) begin
                        red_d = FULL; grn_d = FULL; blu_d = FULL;
                    end
                end
                PAT_MOVING: begin
                    blu_d = FULL;
                    if (in_bar) begin
                        red_d = FULL; grn_d = FULL;
                    end
                end
                default: ;
            endcase
        end
        hsync_d       = t_hsync;
        vsync_d       = t_vsync;
        active_d      = t_active;
        frame_start_d = t_frame_start;
        col_d         = t_col;
        row_d         = t_row;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pattern_q     <= PAT_BLACK;
            bar_pos_q     <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            red_q         <= '0;
            grn_q         <= '0;
            blu_q         <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
        end else begin
            pattern_q     <= pattern_d;
            bar_pos_q     <= bar_pos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            grn_q         <= grn_d;
            blu_q         <= blu_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            col_q         <= col_d;
            row_q         <= row_d;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Red         = red_q;
    assign o_Grn         = grn_q;
    assign o_Blu         = blu_q;
    assign o_Active      = active_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Col         = col_q;
    assign o_Row         = row_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen on a shrunken raster (80x14 clocks/frame).
// Every clock is compared against a raster model driven by pixel index arithmetic.
// Table vectors, sync/frame timing, mid-frame pattern change, reset and bar wrap.
module tb_vga_pattern_gen;

    localparam int VW   = 3;
    localparam int AC   = 64;
    localparam int AR   = 8;
    localparam int HFP  = 4;
    localparam int HSW  = 8;
    localparam int HBP  = 4;
    localparam int VFP  = 2;
    localparam int VSW  = 2;
    localparam int VBP  = 2;
    localparam int CHK  = 2;
    localparam int BW   = 8;
    localparam int STEP = 4;
    localparam int TC    = AC + HFP + HSW + HBP;   // 80
    localparam int TR    = AR + VFP + VSW + VBP;   // 14
    localparam int FRAME = TC * TR;                // 1120

    logic          clk = 1'b0;
    logic          i_Rst;
    logic [2:0]    i_Pattern;
    logic          o_HSync, o_VSync, o_Active, o_Frame_Start;
    logic [VW-1:0] o_Red, o_Grn, o_Blu;
    logic [9:0]    o_Col, o_Row;

    vga_pattern_gen #(
        .VIDEO_WIDTH(VW), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CHK_LOG2(CHK), .BAR_W(BW), .BAR_STEP(STEP)
    ) dut (
        .i_Clk(clk), .i_Rst(i_Rst), .i_Pattern(i_Pattern),
        .o_HSync(o_HSync), .o_VSync(o_VSync),
        .o_Red(o_Red), .o_Grn(o_Grn), .o_Blu(o_Blu),
        .o_Active(o_Active), .o_Frame_Start(o_Frame_Start),
        .o_Col(o_Col), .o_Row(o_Row)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_idx    = 0;   // raster index of the pixel the DUT will emit next
    int m_frame  = 0;   // frames started since reset release
    int m_pat    = 0;

    localparam logic [32:0] RESET_VEC = {1'b1, 1'b1, 9'd0, 1'b0, 1'b0, 20'd0};

    typedef struct {
        logic [2:0] pat;
        int         col;
        int         row;
        logic [8:0] rgb;   // {R,G,B} channel values
        logic       act;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [32:0] actual_vec();
        return {o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Active, o_Frame_Start, o_Col, o_Row};
    endfunction

    // Bar positions cycle 0, STEP, ..., ACTIVE-BW and then restart.
    function automatic int bar_at(int frame);
        int n_pos;
        n_pos = (AC - BW) / STEP + 1;
        return (frame % n_pos) * STEP;
    endfunction

    function automatic logic [32:0] model_out(int p, int c, int r, int frame);
        logic [2:0] rgb;
        logic       act, hs, vs, fs;
        int         k, bar;
        logic [9:0] c10, r10;
        act = (c < AC) && (r < AR);
        rgb = 3'b000;
        if (act) begin
            case (p)
                1: rgb = 3'b111;
                2: rgb = (c < AC / 2) ? 3'b110 : 3'b100;
                3: begin k = c / (AC / 8); rgb = k[2:0]; end
                4: rgb = ((((c >> CHK) ^ (r >> CHK)) & 1) != 0) ? 3'b111 : 3'b000;
                5: rgb = (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) ? 3'b111 : 3'b000;
                6: begin
                    bar = bar_at(frame);
                    rgb = (c >= bar && c < bar + BW) ? 3'b111 : 3'b001;
                end
                default: rgb = 3'b000;
            endcase
        end
        hs  = !(c >= AC + HFP && c < AC + HFP + HSW);
        vs  = !(r >= AR + VFP && r < AR + VFP + VSW);
        fs  = (c == 0) && (r == 0);
        c10 = c[9:0];
        r10 = r[9:0];
        return {hs, vs, {VW{rgb[2]}}, {VW{rgb[1]}}, {VW{rgb[0]}}, act, fs, c10, r10};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait expired, got no event, expected one", name);
    endtask

    // One clock; afterwards the model predicts the full output word and it is compared.
    task automatic tick();
        logic [32:0] exp;
        int c, r;
        @(posedge clk);
        #1;
        if (i_Rst) begin
            m_idx   = 0;
            m_frame = 0;
            exp     = RESET_VEC;
        end else begin
            c = m_idx % TC;
            r = m_idx / TC;
            if (m_idx == 0) m_pat = int'(i_Pattern);
            exp = model_out(m_pat, c, r, m_frame);
            m_idx++;
            if (m_idx == FRAME) begin
                m_idx = 0;
                m_frame++;
            end
        end
        check($sformatf("pixel f%0d idx%0d", m_frame, m_idx), 64'(actual_vec()), 64'(exp));
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_Frame_Start && n < FRAME + 4);
        if (!o_Frame_Start) timeout("wait_frame_start");
    endtask

    task automatic goto(int c, int r);
        int n;
        n = 0;
        while (!(int'(o_Col) == c && int'(o_Row) == r) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (!(int'(o_Col) == c && int'(o_Row) == r)) timeout($sformatf("goto(%0d,%0d)", c, r));
    endtask

    task automatic set_pat(int p);
        i_Pattern = 3'(p);
        wait_fs();
    endtask

    initial begin
        int hfirst, hcnt, vfirst, vcnt, fs_first, fs_cnt, first_white;

        vecs.push_back('{3'd2, 31, 2, 9'o770, 1'b1});
        vecs.push_back('{3'd2, 32, 2, 9'o700, 1'b1});
        vecs.push_back('{3'd2, 64, 2, 9'o000, 1'b0});
        vecs.push_back('{3'd3,  0, 1, 9'o000, 1'b1});
        vecs.push_back('{3'd3,  8, 1, 9'o007, 1'b1});
        vecs.push_back('{3'd3, 23, 1, 9'o070, 1'b1});
        vecs.push_back('{3'd3, 48, 1, 9'o770, 1'b1});
        vecs.push_back('{3'd3, 63, 1, 9'o777, 1'b1});
        vecs.push_back('{3'd4,  0, 0, 9'o000, 1'b1});
        vecs.push_back('{3'd4,  4, 0, 9'o777, 1'b1});
        vecs.push_back('{3'd4,  4, 4, 9'o000, 1'b1});
        vecs.push_back('{3'd4,  0, 5, 9'o777, 1'b1});
        vecs.push_back('{3'd5,  5, 0, 9'o777, 1'b1});
        vecs.push_back('{3'd5,  0, 3, 9'o777, 1'b1});
        vecs.push_back('{3'd5,  5, 3, 9'o000, 1'b1});
        vecs.push_back('{3'd5, 63, 3, 9'o777, 1'b1});
        vecs.push_back('{3'd5,  5, 7, 9'o777, 1'b1});
        vecs.push_back('{3'd1, 10, 3, 9'o777, 1'b1});
        vecs.push_back('{3'd1, 64, 3, 9'o000, 1'b0});
        vecs.push_back('{3'd1,  0, 8, 9'o000, 1'b0});
        vecs.push_back('{3'd7, 10, 3, 9'o000, 1'b1});
        vecs.push_back('{3'd0, 10, 3, 9'o000, 1'b1});

        // Reset state, then release and look at two full frames of timing.
        i_Rst     = 1'b1;
        i_Pattern = 3'd0;
        #1;
        check("reset_state", 64'(actual_vec()), 64'(RESET_VEC));
        tick();
        tick();
        i_Rst = 1'b0;
        tick();
        check("first_pixel_fs", 64'({o_Frame_Start, o_Col, o_Row}), 64'({1'b1, 20'd0}));
        hfirst = -1; hcnt = 0; vfirst = -1; vcnt = 0; fs_first = -1; fs_cnt = 0;
        for (int i = 1; i <= 2 * FRAME; i++) begin
            tick();
            if (i < FRAME && !o_HSync && o_Row == 10'd0) begin
                if (hfirst < 0) hfirst = int'(o_Col);
                hcnt++;
            end
            if (i < FRAME && !o_VSync && o_Col == 10'd0) begin
                if (vfirst < 0) vfirst = int'(o_Row);
                vcnt++;
            end
            if (o_Frame_Start) begin
                if (fs_first < 0) fs_first = i;
                fs_cnt++;
            end
        end
        check("hsync_start_col", 64'(hfirst), 64'(AC + HFP));
        check("hsync_width", 64'(hcnt), 64'(HSW));
        check("vsync_start_row", 64'(vfirst), 64'(AR + VFP));
        check("vsync_lines", 64'(vcnt), 64'(VSW));
        check("frame_period", 64'(fs_first), 64'(FRAME));
        check("frame_pulses", 64'(fs_cnt), 64'(2));

        // Table-driven pattern pixels.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].pat != vecs[i - 1].pat) set_pat(int'(vecs[i].pat));
            goto(vecs[i].col, vecs[i].row);
            check($sformatf("vec%0d p%0d (%0d,%0d)", i, vecs[i].pat, vecs[i].col, vecs[i].row),
                  64'({o_Red, o_Grn, o_Blu, o_Active}), 64'({vecs[i].rgb, vecs[i].act}));
        end

        // Select changes mid-frame: the checkerboard must hold until the next frame.
        set_pat(4);
        goto(0, 4);
        i_Pattern = 3'd1;
        goto(4, 5);
        check("no_tear_mid_frame", 64'({o_Red, o_Grn, o_Blu}), 64'(9'o000));
        wait_fs();
        check("new_pattern_at_origin", 64'({o_Red, o_Grn, o_Blu}), 64'(9'o777));

        // Asynchronous reset during horizontal sync.
        goto(70, 5);
        check("hsync_low_before_reset", 64'(o_HSync), 64'(0));
        #2;
        i_Rst = 1'b1;
        #1;
        check("async_reset_immediate", 64'(actual_vec()), 64'(RESET_VEC));
        tick();
        tick();
        i_Rst = 1'b0;
        tick();
        check("fs_after_mid_reset", 64'({o_Frame_Start, o_Col, o_Row}), 64'({1'b1, 20'd0}));

        // Moving bar from a fresh reset: first white column of row 0 per frame.
        i_Rst     = 1'b1;
        i_Pattern = 3'd6;
        tick();
        i_Rst = 1'b0;
        tick();
        for (int f = 0; f <= 16; f++) begin
            if (f > 0) wait_fs();
            first_white = -1;
            for (int c = 0; c < AC; c++) begin
                if (o_Red == '1 && first_white < 0) first_white = int'(o_Col);
                tick();
            end
            check($sformatf("bar_pos frame%0d", f), 64'(first_white), 64'(bar_at(f)));
        end

        // Random select changes, every pixel checked by the model.
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) i_Pattern = 3'($urandom_range(0, 7));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
